// File: rtl/fir_interp_halfband_mc_pkg.sv
// ---------------------------------------------------------------------------
// fir_interp_halfband_mc_pkg
// Shared definitions for the multichannel halfband 2x interpolator:
//   - halfband odd-phase coefficient sets (flat vectors, c_0 in the LSBs,
//     each set sums to 2^16),
//   - the Q-format shift applied after accumulation,
//   - the controller state encoding,
//   - a modular index helper for the circular delay lines.
// ---------------------------------------------------------------------------
package fir_interp_halfband_mc_pkg;

    localparam int Q_SHIFT   = 16;
    localparam int HB_COEF_W = 18;

    localparam logic [4*HB_COEF_W-1:0] HB_COEFS_N4 = {
        18'sd52536, 18'sd18000, -18'sd6000, 18'sd1000
    };

    localparam logic [8*HB_COEF_W-1:0] HB_COEFS_N8 = {
        18'sd82580, -18'sd25600, 18'sd13440, -18'sd7480,
        18'sd4020,  -18'sd1960,  18'sd820,   -18'sd284
    };

    localparam logic [12*HB_COEF_W-1:0] HB_COEFS_N12 = {
        18'sd72696, -18'sd10600, 18'sd5500, -18'sd3350,
        18'sd2150,  -18'sd1400,  18'sd900,  -18'sd560,
        18'sd330,   -18'sd180,   18'sd90,   -18'sd40
    };

    typedef enum logic [2:0] {
        IDLE,
        PH_A,
        MAC,
        DRAIN,
        PH_B
    } state_t;

    // (base - offset) modulo len, for base in [0, len) and offset in [0, len].
    function automatic int wrap_sub(input int base, input int offset, input int len);
        int t;
        t = base - offset;
        if (t < 0) t = t + len;
        return t;
    endfunction

    // Cycles from an accepted input strobe to the phase-B output strobe.
    function automatic int phase_b_latency(input int nch, input int ncoef);
        return 3 + nch * (ncoef + 3);
    endfunction

endpackage

// File: rtl/fir_interp_halfband_mc_mac.sv
// ---------------------------------------------------------------------------
// hb_preadd_mac
// Registered pre-add -> multiply -> accumulate pipeline with a combinational
// round (half-up) and saturate stage on the accumulator.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clears the accumulator on the next edge
//   en          : a/b/coef are a valid tap pair this cycle
//   a, b        : symmetric sample pair (signed, DW)
//   coef        : tap coefficient (signed, COEF_W)
//   result      : sat(round(acc >> Q_SHIFT)), signed DW
// Latency: a pair presented with en in cycle t is in acc after the edge
// ending cycle t+2.
// ---------------------------------------------------------------------------
module hb_preadd_mac
    import fir_interp_halfband_mc_pkg::*;
#(
    parameter int DW     = 18,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DW-1:0]     a,
    input  logic signed [DW-1:0]     b,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [DW-1:0]     result
);
    localparam int PW = DW + 1 + COEF_W;

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-Q_SHIFT){1'b0}}, 1'b1, {(Q_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW:0]        pre;
    logic signed [COEF_W-1:0]  coef_q;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   rounded;
    logic                      v1;
    logic                      v2;

    // Three register stages; the valid bits travel alongside the data so
    // that the accumulator only adds products belonging to real tap pairs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            coef_q <= '0;
            prod   <= '0;
            acc    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
        end else begin
            pre    <= {a[DW-1], a} + {b[DW-1], b};
            coef_q <= coef;
            v1     <= en;
            prod   <= pre * coef_q;
            v2     <= v1;
            if (clr)
                acc <= '0;
            else if (v2)
                acc <= acc + ACC_W'(prod);
        end
    end

    always_comb begin
        rounded = (acc + HALF) >>> Q_SHIFT;
        if (rounded > SAT_HI)
            result = SAT_HI[DW-1:0];
        else if (rounded < SAT_LO)
            result = SAT_LO[DW-1:0];
        else
            result = rounded[DW-1:0];
    end

endmodule

// File: rtl/fir_interp_halfband_mc.sv
// ---------------------------------------------------------------------------
// fir_interp_halfband_mc
// Multichannel halfband 2x interpolator. Every accepted input frame produces
// a phase-A frame (pure delay x[n-N]) two cycles later and a phase-B frame
// (odd-phase filter output) after phase_b_latency(NCH, NCOEF) cycles.
// One pre-add/MAC unit is time-shared across channels.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   sample_in_rdy     : input strobe, sample_in valid this cycle
//   sample_in         : NCH x DW signed, channel 0 in the LSBs
//   sample_out_rdy    : one-cycle strobe per output frame
//   sample_out        : NCH x DW signed output frame, held between strobes
//   sample_out_phase  : 0 = phase A, 1 = phase B
//   busy              : frame in progress, through the phase-B strobe cycle
//   overrun           : pulses the cycle after a dropped input strobe
// ---------------------------------------------------------------------------
module fir_interp_halfband_mc
    import fir_interp_halfband_mc_pkg::*;
#(
    parameter int                         NCH    = 2,
    parameter int                         DW     = 18,
    parameter int                         NCOEF  = 8,
    parameter int                         COEF_W = 18,
    parameter logic [NCOEF*COEF_W-1:0]    COEFS  = HB_COEFS_N8,
    parameter int                         ACC_W  = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_in_rdy,
    input  logic [NCH*DW-1:0]     sample_in,
    output logic                  sample_out_rdy,
    output logic [NCH*DW-1:0]     sample_out,
    output logic                  sample_out_phase,
    output logic                  busy,
    output logic                  overrun
);
    localparam int TAPS2 = 2 * NCOEF;
    localparam int PTR_W = $clog2(TAPS2);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = (NCOEF > 4) ? $clog2(NCOEF) : 2;

    state_t state;
    state_t state_next;

    logic signed [DW-1:0]     dline [NCH][TAPS2];
    logic signed [DW-1:0]     hold  [NCH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         head_next;
    logic [CH_W-1:0]          ch;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     emit_a;
    logic                     emit_b;
    logic                     mac_en;
    logic                     mac_clr;
    logic                     store;
    logic signed [DW-1:0]     mac_a;
    logic signed [DW-1:0]     mac_b;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DW-1:0]     mac_result;

    // head always points at the newest sample x[n] of every channel.
    assign head_next = (head == PTR_W'(TAPS2 - 1)) ? '0 : head + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Input is only taken in IDLE with busy low; busy stays high through the
    // phase-B strobe cycle, so a strobe landing there is dropped.
    // DRAIN spends three cycles per channel: two to flush the MAC pipeline,
    // one to latch the rounded result into the channel's hold register.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        emit_a     = 1'b0;
        emit_b     = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        store      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_in_rdy && !busy) begin
                    accept     = 1'b1;
                    state_next = PH_A;
                end
            end
            PH_A: begin
                emit_a     = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (cnt == '0);
                if (cnt == CNT_W'(NCOEF - 1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (cnt == CNT_W'(2)) begin
                    store      = 1'b1;
                    state_next = (ch == CH_W'(NCH - 1)) ? PH_B : MAC;
                end
            end
            PH_B: begin
                emit_b     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt walks the taps in MAC and the flush steps in DRAIN; ch advances
    // after each channel's store.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ch  <= '0;
        end else begin
            case (state)
                MAC: begin
                    cnt <= (cnt == CNT_W'(NCOEF - 1)) ? '0 : cnt + CNT_W'(1);
                end
                DRAIN: begin
                    if (cnt == CNT_W'(2)) begin
                        cnt <= '0;
                        ch  <= (ch == CH_W'(NCH - 1)) ? '0 : ch + CH_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                    ch  <= '0;
                end
            endcase
        end
    end

    // Tap k pairs x[n-k] with its mirror x[n-2N+1+k].
    always_comb begin
        mac_a    = '0;
        mac_b    = '0;
        mac_coef = '0;
        if (state == MAC) begin
            mac_a    = dline[ch][PTR_W'(wrap_sub(int'(head), int'(cnt), TAPS2))];
            mac_b    = dline[ch][PTR_W'(wrap_sub(int'(head), TAPS2 - 1 - int'(cnt), TAPS2))];
            mac_coef = COEFS[int'(cnt)*COEF_W +: COEF_W];
        end
    end

    hb_preadd_mac #(
        .DW     (DW),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .coef   (mac_coef),
        .result (mac_result)
    );

    // Delay lines, per-channel result holding and the output/status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c] <= '0;
                for (int t = 0; t < TAPS2; t++)
                    dline[c][t] <= '0;
            end
            head             <= '0;
            sample_out       <= '0;
            sample_out_rdy   <= 1'b0;
            sample_out_phase <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            sample_out_rdy <= emit_a | emit_b;
            overrun        <= sample_in_rdy & ~accept;
            if (sample_out_rdy && sample_out_phase)
                busy <= 1'b0;
            if (accept) begin
                head <= head_next;
                busy <= 1'b1;
                for (int c = 0; c < NCH; c++)
                    dline[c][head_next] <= sample_in[c*DW +: DW];
            end
            if (emit_a) begin
                sample_out_phase <= 1'b0;
                for (int c = 0; c < NCH; c++)
                    sample_out[c*DW +: DW] <= dline[c][PTR_W'(wrap_sub(int'(head), NCOEF, TAPS2))];
            end
            if (emit_b) begin
                sample_out_phase <= 1'b1;
                for (int c = 0; c < NCH; c++)
                    sample_out[c*DW +: DW] <= hold[c];
            end
            if (store)
                hold[ch] <= mac_result;
        end
    end

endmodule

// File: tb/tb_fir_interp_halfband_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_interp_halfband_mc
// Bench for the halfband interpolator: a 2-channel and a 4-channel instance,
// each compared against a history-array model of the filter equations.
// ---------------------------------------------------------------------------
module tb_fir_interp_halfband_mc;

    localparam int DW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset2, in_rdy2, out_rdy2, phase2, busy2, ovr2;
    logic [2*DW-1:0] in2, out2;
    logic            reset4, in_rdy4, out_rdy4, phase4, busy4, ovr4;
    logic [4*DW-1:0] in4, out4;

    fir_interp_halfband_mc dut (
        .clk              (clk),
        .reset            (reset2),
        .sample_in_rdy    (in_rdy2),
        .sample_in        (in2),
        .sample_out_rdy   (out_rdy2),
        .sample_out       (out2),
        .sample_out_phase (phase2),
        .busy             (busy2),
        .overrun          (ovr2)
    );

    fir_interp_halfband_mc #(.NCH(4)) dut4 (
        .clk              (clk),
        .reset            (reset4),
        .sample_in_rdy    (in_rdy4),
        .sample_in        (in4),
        .sample_out_rdy   (out_rdy4),
        .sample_out       (out4),
        .sample_out_phase (phase4),
        .busy             (busy4),
        .overrun          (ovr4)
    );

    int total = 0;
    int bad   = 0;
    int coef [8] = '{-284, 820, -1960, 4020, -7480, 13440, -25600, 82580};
    int hist2 [2][16];
    int hist4 [4][16];

    // ---------------- reference model ----------------
    function automatic int sext(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // h[j] = x[n-j]
    function automatic int model_b(input int h[16]);
        longint acc = 0;
        for (int k = 0; k < 8; k++)
            acc += longint'(coef[k]) * longint'(h[k] + h[15-k]);
        acc = (acc + 32768) >>> 16;
        if (acc > 131071)  acc = 131071;
        if (acc < -131072) acc = -131072;
        return int'(acc);
    endfunction

    task automatic push2(input logic [2*DW-1:0] s);
        for (int c = 0; c < 2; c++) begin
            for (int i = 15; i > 0; i--) hist2[c][i] = hist2[c][i-1];
            hist2[c][0] = sext(s[c*DW +: DW]);
        end
    endtask

    task automatic push4(input logic [4*DW-1:0] s);
        for (int c = 0; c < 4; c++) begin
            for (int i = 15; i > 0; i--) hist4[c][i] = hist4[c][i-1];
            hist4[c][0] = sext(s[c*DW +: DW]);
        end
    endtask

    function automatic logic [2*DW-1:0] exp_a2();
        logic [2*DW-1:0] r;
        for (int c = 0; c < 2; c++) r[c*DW +: DW] = DW'(hist2[c][8]);
        return r;
    endfunction

    function automatic logic [2*DW-1:0] exp_b2();
        logic [2*DW-1:0] r;
        int h [16];
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) h[i] = hist2[c][i];
            r[c*DW +: DW] = DW'(model_b(h));
        end
        return r;
    endfunction

    function automatic logic [4*DW-1:0] exp_a4();
        logic [4*DW-1:0] r;
        for (int c = 0; c < 4; c++) r[c*DW +: DW] = DW'(hist4[c][8]);
        return r;
    endfunction

    function automatic logic [4*DW-1:0] exp_b4();
        logic [4*DW-1:0] r;
        int h [16];
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++) h[i] = hist4[c][i];
            r[c*DW +: DW] = DW'(model_b(h));
        end
        return r;
    endfunction

    function automatic logic [2*DW-1:0] rand2();
        logic [2*DW-1:0] r;
        for (int c = 0; c < 2; c++) r[c*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // ---------------- drivers (capture only, no checking) ----------------
    // Strobe one frame; return captured outputs and their latency in cycles
    // after the strobe cycle (-1 if not seen). Returns in the cycle after the
    // phase-B strobe.
    task automatic send2(input logic [2*DW-1:0] s, output logic [2*DW-1:0] ya,
                         output logic [2*DW-1:0] yb, output int la, output int lb);
        ya = '0; yb = '0; la = -1; lb = -1;
        in2 = s; in_rdy2 = 1'b1;
        @(posedge clk); #1;
        in_rdy2 = 1'b0;
        for (int i = 1; i <= 60 && lb < 0; i++) begin
            if (out_rdy2 && !phase2) begin ya = out2; la = i; end
            if (out_rdy2 && phase2)  begin yb = out2; lb = i; end
            @(posedge clk); #1;
        end
    endtask

    task automatic send4(input logic [4*DW-1:0] s, output logic [4*DW-1:0] ya,
                         output logic [4*DW-1:0] yb, output int la, output int lb);
        ya = '0; yb = '0; la = -1; lb = -1;
        in4 = s; in_rdy4 = 1'b1;
        @(posedge clk); #1;
        in_rdy4 = 1'b0;
        for (int i = 1; i <= 80 && lb < 0; i++) begin
            if (out_rdy4 && !phase4) begin ya = out4; la = i; end
            if (out_rdy4 && phase4)  begin yb = out4; lb = i; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2*DW-1:0] s, ya, yb;
        int la, lb;
        in_rdy2 = 1'b0; in2 = '0; reset2 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (out2 !== '0) begin
            bad++; $display("[TB] FAIL reset_out got=%h want=0", out2);
        end
        total++;
        if ({out_rdy2, phase2, busy2, ovr2} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {out_rdy2, phase2, busy2, ovr2});
        end
        reset2 = 1'b0;
        hist2 = '{default: '{default: 0}};
        @(posedge clk); #1;
        s = rand2();
        push2(s);
        send2(s, ya, yb, la, lb);
        total++;
        if (la != 2) begin bad++; $display("[TB] FAIL reset_lat_a got=%0d want=2", la); end
        total++;
        if (lb != 25) begin bad++; $display("[TB] FAIL reset_lat_b got=%0d want=25", lb); end
        total++;
        if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL reset_a got=%h want=%h", ya, exp_a2()); end
        total++;
        if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL reset_b got=%h want=%h", yb, exp_b2()); end
    endtask

    task automatic test_impulse();
        logic [2*DW-1:0] s, ya, yb;
        int la, lb;
        for (int n = 0; n < 18; n++) begin
            s = (n == 0) ? {18'd0, 18'd65536} : '0;
            push2(s);
            send2(s, ya, yb, la, lb);
            total++;
            if (la != 2 || lb != 25) begin
                bad++; $display("[TB] FAIL impulse_lat n=%0d got=%0d/%0d want=2/25", n, la, lb);
            end
            total++;
            if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL impulse_a n=%0d got=%h want=%h", n, ya, exp_a2()); end
            total++;
            if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL impulse_b n=%0d got=%h want=%h", n, yb, exp_b2()); end
            repeat (14) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_dc();
        logic [2*DW-1:0] s, ya, yb;
        int la, lb;
        s = {18'd20000, 18'd20000};
        for (int n = 0; n < 20; n++) begin
            push2(s);
            send2(s, ya, yb, la, lb);
            total++;
            if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL dc_a n=%0d got=%h want=%h", n, ya, exp_a2()); end
            total++;
            if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL dc_b n=%0d got=%h want=%h", n, yb, exp_b2()); end
        end
    endtask

    task automatic test_saturation();
        logic [2*DW-1:0] s, ya, yb;
        int la, lb;
        for (int n = 0; n < 20; n++) begin
            s = (n < 10) ? {18'sd131071, 18'sd131071} : {-18'sd131072, -18'sd131072};
            push2(s);
            send2(s, ya, yb, la, lb);
            total++;
            if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL sat_a n=%0d got=%h want=%h", n, ya, exp_a2()); end
            total++;
            if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL sat_b n=%0d got=%h want=%h", n, yb, exp_b2()); end
        end
    endtask

    task automatic test_overrun();
        logic [2*DW-1:0] s, ya, yb;
        logic ovr_ok;
        int strobes;
        s = rand2();
        push2(s);
        ovr_ok = 1'b1; strobes = 0; ya = '0; yb = '0;
        in2 = s; in_rdy2 = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 40; i++) begin
            if (ovr2 !== ((i == 6) || (i == 26))) ovr_ok = 1'b0;
            if (out_rdy2) begin
                strobes++;
                if (phase2) yb = out2; else ya = out2;
            end
            in_rdy2 = (i == 5) || (i == 25);
            in2 = rand2();
            @(posedge clk); #1;
        end
        total++;
        if (!ovr_ok) begin bad++; $display("[TB] FAIL overrun_pulse got=wrong pattern want=pulses at +6,+26"); end
        total++;
        if (strobes != 2) begin bad++; $display("[TB] FAIL overrun_strobes got=%0d want=2", strobes); end
        total++;
        if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL overrun_a got=%h want=%h", ya, exp_a2()); end
        total++;
        if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL overrun_b got=%h want=%h", yb, exp_b2()); end
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] s, ya, yb;
        int la, lb;
        for (int n = 0; n < 25; n++) begin
            s = rand2();
            push2(s);
            send2(s, ya, yb, la, lb);
            total++;
            if (la != 2 || lb != 25) begin
                bad++; $display("[TB] FAIL b2b_lat n=%0d got=%0d/%0d want=2/25", n, la, lb);
            end
            total++;
            if (ya !== exp_a2()) begin bad++; $display("[TB] FAIL b2b_a n=%0d got=%h want=%h", n, ya, exp_a2()); end
            total++;
            if (yb !== exp_b2()) begin bad++; $display("[TB] FAIL b2b_b n=%0d got=%h want=%h", n, yb, exp_b2()); end
        end
    endtask

    task automatic test_nch4_reset_mid_mac();
        logic [4*DW-1:0] s, ya, yb;
        int la, lb;
        logic saw_b;
        in_rdy4 = 1'b0; in4 = '0; reset4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset4 = 1'b0;
        hist4 = '{default: '{default: 0}};
        for (int n = 0; n < 18; n++) begin
            s = '0;
            if (n == 0)
                for (int c = 0; c < 4; c++) s[c*DW +: DW] = DW'(16384 * (c + 1));
            push4(s);
            send4(s, ya, yb, la, lb);
            total++;
            if (la != 2 || lb != 47) begin
                bad++; $display("[TB] FAIL nch4_lat n=%0d got=%0d/%0d want=2/47", n, la, lb);
            end
            total++;
            if (ya !== exp_a4()) begin bad++; $display("[TB] FAIL nch4_a n=%0d got=%h want=%h", n, ya, exp_a4()); end
            total++;
            if (yb !== exp_b4()) begin bad++; $display("[TB] FAIL nch4_b n=%0d got=%h want=%h", n, yb, exp_b4()); end
        end
        // strobe at T, reset sampled at the end of cycle T+10
        for (int c = 0; c < 4; c++) in4[c*DW +: DW] = DW'($urandom);
        in_rdy4 = 1'b1;
        @(posedge clk); #1;
        in_rdy4 = 1'b0;
        saw_b = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            if (i == 11) begin
                total++;
                if ({out4, out_rdy4, phase4, busy4, ovr4} !== '0) begin
                    bad++; $display("[TB] FAIL nch4_reset_out got=%h/%b want=0", out4, {out_rdy4, phase4, busy4, ovr4});
                end
            end
            if (i >= 11 && out_rdy4) saw_b = 1'b1;
            reset4 = (i == 10);
            @(posedge clk); #1;
        end
        total++;
        if (saw_b) begin bad++; $display("[TB] FAIL nch4_no_strobe got=strobe want=none"); end
        hist4 = '{default: '{default: 0}};
        for (int c = 0; c < 4; c++) s[c*DW +: DW] = DW'($urandom);
        push4(s);
        send4(s, ya, yb, la, lb);
        total++;
        if (ya !== exp_a4()) begin bad++; $display("[TB] FAIL nch4_post_a got=%h want=%h", ya, exp_a4()); end
        total++;
        if (yb !== exp_b4() || lb != 47) begin
            bad++; $display("[TB] FAIL nch4_post_b got=%h lat=%0d want=%h lat=47", yb, lb, exp_b4());
        end
    endtask

    initial begin
        reset2 = 1'b1; in_rdy2 = 1'b0; in2 = '0;
        reset4 = 1'b1; in_rdy4 = 1'b0; in4 = '0;
        test_reset();
        test_impulse();
        test_overrun();
        test_impulse();
        test_dc();
        test_saturation();
        test_back_to_back();
        test_nch4_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
